// File: rtl/input_byte_store_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_byte_store_pkg                                                 |
// | Shared types and constants for the puzzle-input byte store.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package input_byte_store_pkg;

  // Load-side control state: filling the store, or frozen and readable.
  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int BYTE_W = 8;

  // Value returned on any read that does not hit a stored byte.
  localparam logic [BYTE_W-1:0] ROM_PAD_BYTE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/input_byte_store_byte_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_ram                                                             |
// | Simple dual-port byte RAM: one write port, one synchronous read      |
// | port with 1-cycle latency, no reset (block-RAM friendly).            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module byte_ram
  import input_byte_store_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [BYTE_W-1:0]    i_wr_data,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [BYTE_W-1:0]    o_rd_data
);

  localparam int c_DEPTH = 2 ** ADDR_BITS;

  logic [BYTE_W-1:0] r_mem [c_DEPTH];
  logic [BYTE_W-1:0] r_rd_data;

  // Write port and registered read port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/input_byte_store.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_byte_store                                                     |
// | Loads the puzzle input from a byte stream, then answers the core's   |
// | rom_addr -> rom_data/rom_valid reads with 1-cycle latency.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module input_byte_store
  import input_byte_store_pkg::*;
#(
  parameter int N_ADDR_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BYTE_W-1:0]      i_in_data,
  input  logic                   i_in_valid,
  input  logic                   i_in_last,
  output logic                   o_in_ready,
  input  logic                   i_reload,
  input  logic [N_ADDR_BITS:0]   i_rom_addr,
  output logic [BYTE_W-1:0]      o_rom_data,
  output logic                   o_rom_valid,
  output logic                   o_loaded,
  output logic [N_ADDR_BITS:0]   o_length,
  output logic                   o_overflow
);

  // Capacity and increment expressed at the full length width so the
  // "room left" compare and the address compare never truncate.
  localparam logic [N_ADDR_BITS:0] c_DEPTH = {1'b1, {N_ADDR_BITS{1'b0}}};
  localparam logic [N_ADDR_BITS:0] c_ONE   = {{N_ADDR_BITS{1'b0}}, 1'b1};

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_loaded;
  logic [N_ADDR_BITS:0]   r_length;
  logic                   r_overflow;
  logic                   r_rd_hit;

  logic                   w_beat;
  logic                   w_space;
  logic                   w_wr_en;
  logic [BYTE_W-1:0]      w_ram_q;

  // A beat only counts in LOAD and never in a reload cycle.
  assign w_beat  = (r_state == LOAD) && i_in_valid && !i_reload;
  assign w_space = (r_length < c_DEPTH);
  assign w_wr_en = w_beat && w_space;

  // Load control: length/overflow bookkeeping and LOAD -> READY on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LOAD;
      r_in_ready <= 1'b1;
      r_loaded   <= 1'b0;
      r_length   <= '0;
      r_overflow <= 1'b0;
    end else if (i_reload) begin
      r_state    <= LOAD;
      r_in_ready <= 1'b1;
      r_loaded   <= 1'b0;
      r_length   <= '0;
      r_overflow <= 1'b0;
    end else if (w_beat) begin
      if (w_space) begin
        r_length <= r_length + c_ONE;
      end else begin
        r_overflow <= 1'b1;
      end
      if (i_in_last) begin
        r_state    <= READY;
        r_in_ready <= 1'b0;
        r_loaded   <= 1'b1;
      end
    end
  end

  // Hit flag registered alongside the RAM read so both land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_hit <= 1'b0;
    end else begin
      r_rd_hit <= r_loaded && (i_rom_addr < r_length);
    end
  end

  byte_ram #(
    .ADDR_BITS (N_ADDR_BITS)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_length[N_ADDR_BITS-1:0]),
    .i_wr_data (i_in_data),
    .i_rd_addr (i_rom_addr[N_ADDR_BITS-1:0]),
    .o_rd_data (w_ram_q)
  );

  // Pad mux after the RAM register; a cleared hit flag forces the pad byte,
  // which also makes rom_data read as zero as soon as reset asserts.
  assign o_rom_data  = r_rd_hit ? w_ram_q : ROM_PAD_BYTE;
  assign o_rom_valid = r_rd_hit;
  assign o_in_ready  = r_in_ready;
  assign o_loaded    = r_loaded;
  assign o_length    = r_length;
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_input_byte_store.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_input_byte_store                                                  |
// | Scoreboard bench: a byte-array model predicts every read response,   |
// | a monitor compares it one cycle later.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_input_byte_store;

  localparam int NB  = 4;
  localparam int AW  = NB + 1;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid, in_last, reload;
  logic [AW-1:0] rom_addr;
  logic          in_ready, rom_valid, loaded, overflow;
  logic [7:0]    rom_data;
  logic [AW-1:0] length;

  always #5 clk = ~clk;

  input_byte_store #(.N_ADDR_BITS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_data(in_data), .i_in_valid(in_valid), .i_in_last(in_last),
    .o_in_ready(in_ready), .i_reload(reload), .i_rom_addr(rom_addr),
    .o_rom_data(rom_data), .o_rom_valid(rom_valid), .o_loaded(loaded),
    .o_length(length), .o_overflow(overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    int         a;
  } exp_t;
  exp_t q[$];

  // Reference model: a plain byte array plus a count, a sticky drop flag
  // and a "file complete" flag.
  logic [7:0] m_mem [CAP];
  int         m_len = 0;
  bit         m_ovf = 0;
  bit         m_loaded = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model step at each edge: predict the read from pre-edge contents, then absorb the beat.
  always @(posedge clk) begin
    exp_t e;
    e.a = int'(rom_addr);
    if (!rst_n) begin
      e.v = 1'b0;
      e.d = 8'h00;
      m_len = 0; m_ovf = 0; m_loaded = 0;
    end else begin
      e.v = m_loaded && (int'(rom_addr) < m_len);
      e.d = e.v ? m_mem[rom_addr[NB-1:0]] : 8'h00;
      if (reload) begin
        m_len = 0; m_ovf = 0; m_loaded = 0;
      end else if (!m_loaded && in_valid) begin
        if (m_len < CAP) begin
          m_mem[m_len] = in_data;
          m_len++;
        end else begin
          m_ovf = 1;
        end
        if (in_last) m_loaded = 1;
      end
    end
    q.push_back(e);
  end

  // Asynchronous reset forgets the file immediately.
  always @(negedge rst_n) begin
    m_len = 0; m_ovf = 0; m_loaded = 0;
  end

  // Monitor: compare the registered read outputs just after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("rom_valid[a=%0d]", e.a), 32'(rom_valid), 32'(e.v));
      chk($sformatf("rom_data[a=%0d]", e.a), 32'(rom_data), 32'(e.d));
    end
  end

  task automatic tick(input bit v, input logic [7:0] d, input bit l, input bit rl, input logic [AW-1:0] a);
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; reload = rl; rom_addr = a;
    @(posedge clk);
    #2;
  endtask

  task automatic load_file(input logic [7:0] b[$], input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) begin
        int n_idle = $urandom_range(0, 2);
        for (int k = 0; k < n_idle; k++)
          tick(1'b0, 8'($urandom), 1'($urandom), 1'b0, AW'($urandom_range(0, 31)));
      end
      tick(1'b1, b[i], (i == b.size() - 1), 1'b0, gaps ? AW'($urandom_range(0, 31)) : AW'(0));
      if (i != b.size() - 1) begin
        chk("in_ready_during_load", 32'(in_ready), 32'd1);
        chk("loaded_during_load", 32'(loaded), 32'd0);
      end
    end
    chk("loaded_after_last", 32'(loaded), 32'd1);
    chk("in_ready_after_last", 32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [7:0] f[$];
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    reload = 1'b0; rom_addr = '0;

    // Reset values
    tick(0, 8'h00, 0, 0, 0);
    tick(0, 8'h00, 0, 0, 0);
    chk("rst_length", 32'(length), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rom_valid", 32'(rom_valid), 32'd0);
    chk("rst_rom_data", 32'(rom_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // "12,34\n" with addr 0 read throughout the load
    f = '{8'h31, 8'h32, 8'h2c, 8'h33, 8'h34, 8'h0a};
    load_file(f, 1'b0);
    chk("len_12_34", 32'(length), 32'd6);
    chk("ovf_12_34", 32'(overflow), 32'd0);
    for (int a = 0; a < 8; a++) tick(0, 8'h00, 0, 0, AW'(a));

    // Reload with a coincident beat, then "ABC"
    tick(1, 8'h55, 1, 1, 0);
    chk("reload_loaded", 32'(loaded), 32'd0);
    chk("reload_length", 32'(length), 32'd0);
    chk("reload_in_ready", 32'(in_ready), 32'd1);
    f = '{8'h41, 8'h42, 8'h43};
    load_file(f, 1'b0);
    chk("len_abc", 32'(length), 32'd3);
    for (int a = 0; a < 4; a++) tick(0, 8'h00, 0, 0, AW'(a));

    // Overflow: 20 bytes into a 16-byte store
    tick(0, 8'h00, 0, 1, 0);
    f = {};
    for (int i = 0; i < 20; i++) f.push_back(8'($urandom));
    load_file(f, 1'b0);
    chk("len_ovf", 32'(length), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int a = 0; a < 18; a++) tick(0, 8'h00, 0, 0, AW'(a));
    for (int k = 0; k < 10; k++) tick(1, 8'($urandom), 1, 0, AW'($urandom_range(0, 31)));
    chk("ready_ignores_beats", 32'(length), 32'd16);

    // Asynchronous reset while data is being served
    tick(0, 8'h00, 0, 1, 0);
    f = '{8'h10, 8'h20, 8'h30, 8'h40};
    load_file(f, 1'b0);
    tick(0, 8'h00, 0, 0, AW'(1));
    chk("pre_rst_valid", 32'(rom_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_length", 32'(length), 32'd0);
    chk("arst_loaded", 32'(loaded), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_rom_valid", 32'(rom_valid), 32'd0);
    chk("arst_rom_data", 32'(rom_data), 32'd0);
    #1;
    rst_n = 1'b1;

    // Randomized files with gaps and random reads
    for (int r = 0; r < 6; r++) begin
      tick(0, 8'h00, 0, 1, 0);
      f = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) f.push_back(8'($urandom));
      load_file(f, 1'b1);
      chk("rand_len", 32'(length), 32'((f.size() > CAP) ? CAP : f.size()));
      chk("rand_ovf", 32'(overflow), 32'(f.size() > CAP));
      for (int k = 0; k < 15; k++)
        tick(1'($urandom), 8'($urandom), 1'($urandom), 1'b0, AW'($urandom_range(0, 31)));
    end

    tick(0, 8'h00, 0, 0, 0);
    tick(0, 8'h00, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_byte_store.md
# input_byte_store

Synthesisable byte store that is the responder side of the puzzle-input read port used by every `dayNN_core`. It accepts the puzzle input as a byte stream (for example from a UART receiver or host DMA) and then serves the core's `rom_addr -> rom_data/rom_valid` reads with the same timing as the simulation-only `rom`. This lets the same core run on hardware unchanged.

## Interface
- `N_ADDR_BITS`, default 16: log2 of storage capacity in bytes; read address is `N_ADDR_BITS+1` bits.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  load-stream byte.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_last`  in  1  qualifies the final byte of the file; only sampled with `in_valid`.
- `in_ready`  out  1  store can accept a byte.
- `reload`  in  1  synchronous pulse: discard contents, return to LOAD.
- `rom_addr`  in  `N_ADDR_BITS+1`  read address from the core.
- `rom_data`  out  8  registered read data.
- `rom_valid`  out  1  registered; `rom_data` holds a real input byte.
- `loaded`  out  1  high in READY; the top level uses it to release core reset.
- `length`  out  `N_ADDR_BITS+1`  number of bytes stored.
- `overflow`  out  1  sticky; more than `2**N_ADDR_BITS` bytes were offered.

## Operation
- States: LOAD (reset state) and READY.
- LOAD
  - `in_ready`=1.
  - On `in_valid`, if `length < 2**N_ADDR_BITS`: write `in_data` at `length`, then `length`+1.
  - Otherwise drop the byte, set `overflow`, leave `length` unchanged, and keep accepting until `in_last` (drain).
  - `in_valid & in_last` goes to READY next cycle. The last byte is stored under the same rule.
- READY
  - `in_ready`=0, `loaded`=1.
  - Input beats are ignored.
  - Contents are frozen.
- `reload` is legal in either state.
  - Next cycle: LOAD, `length`=0, `overflow`=0, `loaded`=0.
  - Any input beat in the `reload` cycle is discarded.
  - `reload` has priority over `in_valid`/`in_last`.
- Reads
  - Every cycle, `rom_valid` <= `loaded & (rom_addr < length)`.
  - `rom_data` <= the stored byte if that condition holds, else 8'h00.
  - `rom_addr >= 2**N_ADDR_BITS` is always invalid; compare at full `N_ADDR_BITS+1` width.
  - Reads in LOAD return `rom_valid`=0 and `rom_data`=0.
- Memory contents are not reset; only the control registers are.
- An empty file is not representable: every beat carries a byte. A file of one byte has `length`=1.

## Timing
- Reset values (async assert, sync deassert at the system level):
  - state LOAD, `in_ready`=1, `loaded`=0, `length`=0, `overflow`=0, `rom_valid`=0, `rom_data`=8'h00.
- Read latency is exactly 1 cycle: `rom_addr` applied before edge k appears on `rom_data/rom_valid` after edge k. This matches `rom`.
- Back-to-back input beats are accepted every cycle; there is no bubble.
- The last-byte write and the LOAD->READY transition happen on the same edge.
  - `loaded` rises 1 cycle after the `in_last` beat.
  - A read issued in the cycle right after that can return the last byte.
- Reset asserted mid-load: all control registers clear immediately, and stored bytes are considered lost.

## Structure
- A shared package holds:
  - the state enum (`LOAD`, `READY`);
  - the byte-width constant (8);
  - the fill value `ROM_PAD_BYTE` = 8'h00.
- One sub-module, `byte_ram`: simple dual-port, `2**N_ADDR_BITS` x 8, one write port, one synchronous read port with 1-cycle latency, no reset. It maps to block RAM.
- The `valid` comparison and the pad mux live in the top block, registered alongside the RAM read. Pipeline the compare by one stage and delay `addr` to match RAM output timing.

## Test plan
- Load "12,34\n" (6 bytes, `in_last` on '\n'), then read addr 0..7:
  - `length`=6 and `loaded` rises 1 cycle after the last beat.
  - Data reads '1','2',',','3','4','\n' with `rom_valid`=1.
  - Addr 6 and 7 give `rom_valid`=0, `rom_data`=0.
- Reads during LOAD at addr 0: `rom_valid`=0 throughout, even after byte 0 is written.
- `N_ADDR_BITS`=4, offer 20 bytes:
  - `length`=16 and `overflow`=1.
  - Bytes 16..19 are dropped; `in_ready` stays 1 until the `in_last` beat.
  - Addr 16 (bit 4 set) gives `rom_valid`=0.
- In READY, pulse `reload` together with an `in_valid` beat:
  - Next cycle: LOAD, `length`=0, beat not stored.
  - Then reload 3 bytes "ABC": reads return A, B, C, and addr 3 is invalid.
- Assert `rst_n`=0 for half a cycle after 4 bytes are loaded: outputs go to reset values immediately, without waiting for `clk`.
- Connect to `day02_core` with `loaded` driving the core's reset release: part 1 and part 2 results match the simulation `rom` run on the same input file.
